// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, head-flit field offsets, FIFO beat
// layout, FSM states and flit builders used by the local network interfaces.
package noc_pkg;

    localparam int unsigned NOC_FLIT_W  = 32;
    localparam int unsigned NOC_COORD_W = 2;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned TYPE_W      = 2;
    localparam int unsigned PAYLOAD_W   = NOC_FLIT_W - TYPE_W;

    localparam int unsigned TYPE_LSB   = 30;
    localparam int unsigned DEST_X_LSB = 28;
    localparam int unsigned DEST_Y_LSB = 26;
    localparam int unsigned SRC_X_LSB  = 24;
    localparam int unsigned SRC_Y_LSB  = 22;
    localparam int unsigned SEQ_LSB    = 14;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_IDLE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2
    } inj_state_e;

    // One buffered core beat; dest fields are only meaningful when first=1.
    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [NOC_COORD_W-1:0] dest_x;
        logic [NOC_COORD_W-1:0] dest_y;
        logic [PAYLOAD_W-1:0]   data;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    function automatic logic [NOC_FLIT_W-1:0] build_head(
        input logic [NOC_COORD_W-1:0] dest_x,
        input logic [NOC_COORD_W-1:0] dest_y,
        input logic [NOC_COORD_W-1:0] src_x,
        input logic [NOC_COORD_W-1:0] src_y,
        input logic [SEQ_W-1:0]       seq
    );
        logic [NOC_FLIT_W-1:0] f;
        f                            = '0;
        f[TYPE_LSB   +: TYPE_W]      = FLIT_HEAD;
        f[DEST_X_LSB +: NOC_COORD_W] = dest_x;
        f[DEST_Y_LSB +: NOC_COORD_W] = dest_y;
        f[SRC_X_LSB  +: NOC_COORD_W] = src_x;
        f[SRC_Y_LSB  +: NOC_COORD_W] = src_y;
        f[SEQ_LSB    +: SEQ_W]       = seq;
        return f;
    endfunction

    function automatic logic [NOC_FLIT_W-1:0] build_payload(input beat_t b);
        logic [TYPE_W-1:0] t;
        t = b.last ? FLIT_TAIL : FLIT_BODY;
        return {t, b.data};
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes registered full/empty flags
// plus their next-cycle values so a client can register its own status outputs.
module noc_flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             full_d_o,
    output logic             empty_d_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Full when pointers differ only in the wrap bit; push and pop may coincide.
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign full_d_o  = full_d;
    assign empty_d_o = empty_d;

endmodule

// File: rtl/noc_packet_injector.sv
// Transmit-side network interface: buffers core beats and emits them as
// HEAD/BODY/TAIL flits on one router input port with valid/ready handshake.
module noc_packet_injector
    import noc_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned COORD_W    = 2,
    parameter int unsigned NODE_X     = 0,
    parameter int unsigned NODE_Y     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 core_valid,
    output logic                 core_ready,
    input  logic [BUS_WIDTH-3:0] core_data,
    input  logic                 core_last,
    input  logic [COORD_W-1:0]   core_dest_x,
    input  logic [COORD_W-1:0]   core_dest_y,
    output logic [BUS_WIDTH-1:0] flit_out,
    input  logic                 flit_ready,
    output logic                 busy
);

    inj_state_e           state_q, state_d;
    logic [BUS_WIDTH-1:0] flit_q, flit_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 first_q, first_d;
    logic                 core_ready_q;
    logic                 busy_q, busy_d;

    beat_t                push_beat;
    beat_t                head_beat;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty, fifo_full_d, fifo_empty_d;
    logic [TYPE_W-1:0]    flit_type;
    logic                 xfer;

    assign push      = core_valid && !fifo_full;
    assign push_beat = '{first:  first_q,
                         last:   core_last,
                         dest_x: core_dest_x,
                         dest_y: core_dest_y,
                         data:   core_data};

    noc_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wdata_i   (push_beat),
        .pop_i     (pop),
        .rdata_o   (head_beat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .full_d_o  (fifo_full_d),
        .empty_d_o (fifo_empty_d)
    );

    assign flit_type = flit_q[TYPE_LSB +: TYPE_W];
    assign xfer      = (flit_type != FLIT_IDLE) && flit_ready;

    // Next-state logic: HEAD is built without popping so the beat still
    // supplies the first payload flit once the head has been accepted.
    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        seq_d   = seq_q;
        pop     = 1'b0;
        first_d = push ? core_last : first_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_beat.first) begin
                        flit_d  = build_head(head_beat.dest_x, head_beat.dest_y,
                                             NOC_COORD_W'(NODE_X), NOC_COORD_W'(NODE_Y),
                                             seq_q);
                        state_d = ST_HEAD;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    pop     = 1'b1;
                    flit_d  = build_payload(head_beat);
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (xfer || flit_type == FLIT_IDLE) begin
                    if (flit_type == FLIT_TAIL) begin
                        flit_d  = '0;
                        state_d = ST_IDLE;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        flit_d = build_payload(head_beat);
                    end else begin
                        flit_d = '0;
                    end
                end
            end
            default: begin
                flit_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || !fifo_empty_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flit_q       <= '0;
            seq_q        <= '0;
            first_q      <= 1'b1;
            core_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_q       <= flit_d;
            seq_q        <= seq_d;
            first_q      <= first_d;
            core_ready_q <= !fifo_full_d;
            busy_q       <= busy_d;
        end
    end

    assign flit_out   = flit_q;
    assign core_ready = core_ready_q;
    assign busy       = busy_q;

    // A presented flit must not change until the router takes it.
    flit_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        (flit_type != FLIT_IDLE && !flit_ready) |=> $stable(flit_q));

endmodule
